// File: rtl/idt_clk_prog.sv
// Serial programmer for the IDT/ICS307 clock synthesizer: shifts a 24-bit word
// MSB first on idt_sclk/idt_data, then pulses idt_strobe to load it.
module idt_clk_prog #(
    parameter int          CLK_DIV       = 4,
    parameter int          STROBE_CYCLES = 4,
    parameter bit          AUTO_INIT     = 1'b1,
    parameter logic [23:0] INIT_CFG      = 24'h000000
) (
    input  logic        osc_clk,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [23:0] cfg_data,
    output logic        busy,
    output logic        done,
    output logic        idt_sclk,
    output logic        idt_data,
    output logic        idt_strobe
);

    localparam int MAXC = (CLK_DIV > STROBE_CYCLES) ? CLK_DIV : STROBE_CYCLES;
    localparam int DW   = $clog2(MAXC + 1);
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] STB_LOAD = DW'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT_LO, SHIFT_HI, GAP, STROBE, DONE
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [4:0]    bit_cnt, bit_n;
    logic [23:0]   shreg, shreg_n;
    logic          init_pend, init_n;

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        init_n  = init_pend;
        case (state)
            IDLE, DONE: begin
                // The pending power-up word takes the place of an external accept
                if (init_pend || (cfg_valid && cfg_ready)) begin
                    state_n = SHIFT_LO;
                    div_n   = DIV_LOAD;
                    bit_n   = 5'd23;
                    shreg_n = init_pend ? INIT_CFG : cfg_data;
                    init_n  = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT_LO: begin
                if (div_cnt == '0) begin
                    state_n = SHIFT_HI;
                    div_n   = DIV_LOAD;
                end else begin
                    div_n = div_cnt - 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_cnt == '0) begin
                    div_n = DIV_LOAD;
                    if (bit_cnt == 5'd0) begin
                        state_n = GAP;
                    end else begin
                        state_n = SHIFT_LO;
                        bit_n   = bit_cnt - 5'd1;
                        shreg_n = {shreg[22:0], 1'b0};
                    end
                end else begin
                    div_n = div_cnt - 1'b1;
                end
            end
            GAP: begin
                if (div_cnt == '0) begin
                    state_n = STROBE;
                    div_n   = STB_LOAD;
                end else begin
                    div_n = div_cnt - 1'b1;
                end
            end
            STROBE: begin
                if (div_cnt == '0) state_n = DONE;
                else               div_n   = div_cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each pin is a flop output
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            init_pend  <= AUTO_INIT;
            cfg_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            idt_sclk   <= 1'b0;
            idt_data   <= 1'b0;
            idt_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            init_pend  <= init_n;
            cfg_ready  <= (state_n == IDLE) || (state_n == DONE);
            busy       <= (state_n != IDLE) && (state_n != DONE);
            done       <= (state_n == DONE);
            idt_sclk   <= (state_n == SHIFT_HI);
            idt_data   <= ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) && shreg_n[23];
            idt_strobe <= (state_n == STROBE);
        end
    end

endmodule

// File: tb/tb_idt_clk_prog.sv
// Bench for idt_clk_prog: two instances (power-up programming at D=4/S=4, and
// back-to-back runs at D=1/S=1), words recovered on sclk rises vs a scoreboard.
module tb_idt_clk_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst[2], valid[2], sclk[2], sdat[2], stb[2], busy[2], done[2], ready[2];
    logic [23:0] cdata[2];

    idt_clk_prog #(.CLK_DIV(4), .STROBE_CYCLES(4), .AUTO_INIT(1'b1), .INIT_CFG(24'hA5C3F0)) u_dut0 (
        .osc_clk(clk), .reset(rst[0]), .cfg_valid(valid[0]), .cfg_ready(ready[0]),
        .cfg_data(cdata[0]), .busy(busy[0]), .done(done[0]), .idt_sclk(sclk[0]),
        .idt_data(sdat[0]), .idt_strobe(stb[0]));

    idt_clk_prog #(.CLK_DIV(1), .STROBE_CYCLES(1), .AUTO_INIT(1'b0), .INIT_CFG(24'h000000)) u_dut1 (
        .osc_clk(clk), .reset(rst[1]), .cfg_valid(valid[1]), .cfg_ready(ready[1]),
        .cfg_data(cdata[1]), .busy(busy[1]), .done(done[1]), .idt_sclk(sclk[1]),
        .idt_data(sdat[1]), .idt_strobe(stb[1]));

    int n_run = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and monitor state, one slot per instance
    logic [23:0] q0[$], q1[$];
    logic [23:0] word[2];
    int          nbits[2], stb_len[2];
    bit          stb_seen[2];
    logic        psclk[2], pdat[2];

    function automatic int strobe_len_exp(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                nbits[i] = 0; stb_len[i] = 0; word[i] = '0; psclk[i] = 1'b0; pdat[i] = 1'b0;
            end else begin
                logic [23:0] e;
                bit          have;
                if (valid[i] && ready[i]) begin
                    if (i == 0) q0.push_back(cdata[i]); else q1.push_back(cdata[i]);
                end
                if (sclk[i] && !psclk[i]) begin
                    word[i] = {word[i][22:0], sdat[i]};
                    nbits[i]++;
                end
                if (sdat[i] !== pdat[i]) check("data_changes_sclk_low", {31'd0, sclk[i]}, 32'd0);
                if (stb[i]) begin
                    stb_len[i]++;
                    stb_seen[i] = 1'b1;
                    check("strobe_quiet_after_24", {29'd0, sclk[i], sdat[i], nbits[i] == 24}, 32'd1);
                end
                if (done[i]) begin
                    have = 1'b0; e = '0;
                    if (i == 0) begin have = (q0.size() > 0); if (have) e = q0.pop_front(); end
                    else        begin have = (q1.size() > 0); if (have) e = q1.pop_front(); end
                    check("sb_expected_present", {31'd0, have}, 32'd1);
                    if (have) check("sb_word", {8'd0, word[i]}, {8'd0, e});
                    check("sclk_rises", nbits[i], 24);
                    check("strobe_len", stb_len[i], strobe_len_exp(i));
                    nbits[i] = 0; stb_len[i] = 0; word[i] = '0;
                end
                psclk[i] = sclk[i];
                pdat[i]  = sdat[i];
            end
        end
    end

    task automatic wait_done(input int i, output int at_cyc, output int busy_n);
        busy_n = 0;
        at_cyc = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done[i]) begin at_cyc = cyc; break; end
            if (busy[i]) busy_n++;
        end
        check("done_within_budget", {31'd0, at_cyc != -1}, 32'd1);
    endtask

    initial begin
        int c0, at, bn, ndone;
        int dt[6];
        bit got10;
        rst = '{1'b1, 1'b1}; valid = '{1'b0, 1'b0}; cdata = '{24'd0, 24'd0};
        stb_seen = '{1'b0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check("reset_outputs", {26'd0, sclk[i], sdat[i], stb[i], busy[i], done[i], ready[i]}, 32'd0);

        // Power-up programming of INIT_CFG
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0; c0 = cyc;
        q0.push_back(24'hA5C3F0);
        @(negedge clk);
        check("t0_dut0_ready_low", {30'd0, busy[0], ready[0]}, 32'd0);
        check("t0_dut1_ready_low", {31'd0, ready[1]}, 32'd0);
        @(negedge clk);
        check("t1_dut0_first_bit", {29'd0, busy[0], sclk[0], sdat[0]}, 32'b101);
        check("t1_dut0_ready", {31'd0, ready[0]}, 32'd0);
        check("t1_dut1_idle_ready", {30'd0, busy[1], ready[1]}, 32'b01);
        wait_done(0, at, bn);
        check("init_done_latency", at - c0, 201);

        // External request after idling
        repeat (10) @(posedge clk); #1;
        check("idle_ready", {30'd0, busy[0], ready[0]}, 32'b01);
        valid[0] = 1'b1; cdata[0] = 24'h800001; c0 = cyc;
        @(posedge clk); #1;
        valid[0] = 1'b0; cdata[0] = 24'h0;
        wait_done(0, at, bn);
        check("req_done_latency", at - c0, 201);
        check("req_busy_cycles", bn, 200);

        // Data captured at accept; requests while busy ignored
        @(posedge clk); #1;
        valid[0] = 1'b1; cdata[0] = 24'h000000;
        @(posedge clk); #1;
        valid[0] = 1'b0; cdata[0] = 24'hFFFFFF;
        repeat (20) @(posedge clk); #1;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (50) @(posedge clk); #1;
        valid[0] = 1'b1;
        repeat (3) @(posedge clk); #1;
        valid[0] = 1'b0;
        wait_done(0, at, bn);
        repeat (5) @(negedge clk);
        check("no_rerun_after_ignored", {30'd0, busy[0], ready[0]}, 32'b01);
        check("sb_drained", q0.size(), 0);

        // Reset in the middle of a transfer
        @(posedge clk); #1;
        valid[0] = 1'b1; cdata[0] = 24'h123456; stb_seen[0] = 1'b0;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        got10 = 1'b0;
        for (int k = 0; k < 500 && !got10; k++) begin
            @(negedge clk);
            got10 = (nbits[0] == 10);
        end
        check("reached_bit10", {31'd0, got10}, 32'd1);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        q0.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs_zero",
              {26'd0, sclk[0], sdat[0], stb[0], busy[0], done[0], ready[0]}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_held", {29'd0, ready[0], stb[0], busy[0]}, 32'd0);
        end
        check("abort_no_strobe", {31'd0, stb_seen[0]}, 32'd0);
        @(posedge clk); #1;
        rst[0] = 1'b0; c0 = cyc;
        q0.push_back(24'hA5C3F0);
        wait_done(0, at, bn);
        check("reinit_done_latency", at - c0, 201);

        // Back-to-back runs with cfg_valid held high
        @(posedge clk); #1;
        valid[1] = 1'b1; cdata[1] = 24'($urandom()); c0 = cyc;
        ndone = 0;
        for (int k = 0; k < 400 && ndone < 6; k++) begin
            @(negedge clk);
            if (done[1]) begin dt[ndone] = cyc; ndone++; end
            @(posedge clk); #1;
            cdata[1] = 24'($urandom());
        end
        check("b2b_runs", ndone, 6);
        check("b2b_first_latency", dt[0] - c0, 51);
        for (int j = 1; j < 6; j++) check("b2b_period", dt[j] - dt[j-1], 51);
        valid[1] = 1'b0;
        wait_done(1, at, bn);
        repeat (3) @(negedge clk);
        check("b2b_stops", {30'd0, busy[1], ready[1]}, 32'b01);
        check("sb1_drained", q1.size(), 0);
        check("sb0_drained", q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
